// File: rtl/data_mem_ctrl.sv
// Word-organised data memory controller: byte-masked writes and full-word reads with a
// programmable completion latency. Optional error reporting is enabled by DMEM_ERR_EN.
module data_mem_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_mem_request,
  input  logic        data_mem_we_re,
  input  logic [3:0]  mask_signal,
  input  logic [31:0] alu_out_address,
  input  logic [31:0] store_data_out,
  output logic [31:0] load_data_in,
  output logic        data_mem_valid,
`ifdef DMEM_ERR_EN
  output logic        data_mem_err,
`endif
  output logic        data_mem_busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [31:0]     rdata_q, rdata_d;

  logic            we_q, we_d;
  logic [3:0]      mask_q, mask_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            oor_q, oor_d;

  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic            access;

  assign accept = (state_q == S_IDLE) && data_mem_request;
  assign access = (state_q == S_WAIT) && (cnt_q == 4'd0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (data_mem_request) state_d = S_WAIT;
      S_WAIT: if (cnt_q == 4'd0)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and control derived from the state
  always_comb begin
    data_mem_busy = (state_q == S_WAIT);
    cnt_d         = cnt_q;
    if (accept) begin
      cnt_d = 4'(LATENCY - 1);
    end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    valid_d = access;
    rdata_d = rdata_q;
    if (access && !we_q) begin
      rdata_d = oor_q ? 32'h0 : mem[idx_q];
    end
  end

  // Request fields are captured once at acceptance and held for the whole access
  always_comb begin
    we_d    = we_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    oor_d   = oor_q;
    if (accept) begin
      we_d    = data_mem_we_re;
      mask_d  = mask_signal;
      idx_d   = alu_out_address[AW+1:2];
      wdata_d = store_data_out;
      oor_d   = |alu_out_address[31:AW+2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    mask_q  <= mask_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    oor_q   <= oor_d;
  end

  // Memory array is not reset; an aborted access never reaches this write
  always_ff @(posedge clk) begin
    if (access && we_q && !oor_q) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign load_data_in   = rdata_q;
  assign data_mem_valid = valid_q;

`ifdef DMEM_ERR_EN
  logic mis_q, mis_d;
  logic err_q, err_d;

  always_comb begin
    mis_d = mis_q;
    if (accept) mis_d = (|alu_out_address[1:0]) && (|mask_signal);
    err_d = access && (oor_q || mis_q);
  end

  always_ff @(posedge clk) begin
    mis_q <= mis_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign data_mem_err = err_q;
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^alu_out_address[1:0];
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (DEPTH=1024, LATENCY=2).
module tb_data_mem_ctrl;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        valid;
  logic        busy;
`ifdef DMEM_ERR_EN
  logic        err;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_rd = 32'h0;

  data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_mem_request (req),
    .data_mem_we_re   (we),
    .mask_signal      (mask),
    .alu_out_address  (addr),
    .store_data_out   (wdata),
    .load_data_in     (rdata),
    .data_mem_valid   (valid),
`ifdef DMEM_ERR_EN
    .data_mem_err     (err),
`endif
    .data_mem_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access starting at a negedge; returns at a negedge after valid has dropped
  task automatic do_access(input string tag, input logic w, input logic [3:0] m,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input logic exp_err);
    int  k;
    bit  seen;
    req = 1'b1; we = w; mask = m; addr = a; wdata = d;
    @(posedge clk);
    k = 0; seen = 0;
    while (k < 10 && !seen) begin
      @(negedge clk);
      k++;
      if (valid) seen = 1;
      else if (k == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
    chk({tag, "_latency"}, 32'(k), 32'(LATENCY + 1));
    if (!w) last_rd = exp_rd;
    chk({tag, "_data"}, rdata, last_rd);
`ifdef DMEM_ERR_EN
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
`else
    if (exp_err) begin end
`endif
    req = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(valid), 32'd0);
  endtask

  initial begin
    int nv;
    rst = 1'b0; req = 1'b0; we = 1'b0; mask = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_data", rdata, 32'h0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef DMEM_ERR_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    rst = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid || busy) nv++;
    end
    chk("idle_quiet", 32'(nv), 32'd0);

    // Known contents for word 0 and word 8
    do_access("init_w0", 1'b1, 4'hF, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0);
    do_access("init_w20", 1'b1, 4'hF, 32'h20, 32'h0, 32'h0, 1'b0);

    do_access("wr_full", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_access("rd_full", 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    do_access("wr_byte2", 1'b1, 4'b0100, 32'h10, 32'h00AA0000, 32'h0, 1'b0);
    do_access("rd_byte2", 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0);
    do_access("wr_mask0", 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b0);
    do_access("rd_mask0", 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0);

    // Held read request: one valid every LATENCY+1 cycles, mid-WAIT field changes ignored
    req = 1'b1; we = 1'b0; mask = 4'hF; addr = 32'h10; wdata = 32'h0;
    nv = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("held_valid_%0d", k), 32'(valid), 32'((k % 3) == 0));
      if (valid) begin
        nv++;
        chk($sformatf("held_data_%0d", k), rdata, 32'hDEAABEEF);
      end
      if ((k % 3) == 1) begin
        addr = 32'h20; we = 1'b1; wdata = 32'h0;
      end else if ((k % 3) == 2) begin
        addr = 32'h10; we = 1'b0;
      end
      if (k == 12) req = 1'b0;
    end
    chk("held_count", 32'(nv), 32'd4);
    @(negedge clk);
    chk("held_end", 32'(valid), 32'd0);
    last_rd = 32'hDEAABEEF;
    do_access("rd_after_held", 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0);

    // Reset one cycle after accepting a write aborts it
    req = 1'b1; we = 1'b1; mask = 4'hF; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0; req = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_data", rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("abort_no_valid", 32'(nv), 32'd0);
    last_rd = 32'h0;
    do_access("rd_after_abort", 1'b0, 4'hF, 32'h20, 32'h0, 32'h0, 1'b0);

    // Out of range
    do_access("rd_before_oor", 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0);
    do_access("rd_oor", 1'b0, 4'hF, 32'(DEPTH * 4), 32'h0, 32'h0, 1'b1);
    do_access("wr_oor", 1'b1, 4'hF, 32'(DEPTH * 4), 32'hFFFFFFFF, 32'h0, 1'b1);
    do_access("rd_w0", 1'b0, 4'hF, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);

    // Misaligned: still a word access, flagged only with a nonzero mask
    do_access("rd_mis", 1'b0, 4'hF, 32'h12, 32'h0, 32'hDEAABEEF, 1'b1);
    do_access("rd_mis_m0", 1'b0, 4'h0, 32'h13, 32'h0, 32'hA5A5A5A5 ^ 32'hA5A5A5A5 ^ 32'hDEAABEEF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
